// File: rtl/div_control_if.sv
// Control/status bundle between the divider sequencer and its operand bus and datapath.
// The slave modport is the controller view; master is the datapath/requester view.
interface div_control_if;
  logic       start;
  logic       bus_ack;
  logic       dividend_sign;
  logic       divisor_sign;
  logic       divisor_zero;
  logic       rem_ge;
  logic [1:0] Lc;
  logic       bus_req;
  logic       bus_sel;
  logic       shift_en;
  logic       sub_en;
  logic       q_bit;
  logic       negate_q;
  logic       negate_r;
  logic       busy;
  logic       done;
  logic       div_by_zero;
  logic [4:0] step_cnt;

  modport master (
    output start, bus_ack, dividend_sign, divisor_sign, divisor_zero, rem_ge,
    input  Lc, bus_req, bus_sel, shift_en, sub_en, q_bit, negate_q, negate_r,
    input  busy, done, div_by_zero, step_cnt
  );

  modport slave (
    input  start, bus_ack, dividend_sign, divisor_sign, divisor_zero, rem_ge,
    output Lc, bus_req, bus_sel, shift_en, sub_en, q_bit, negate_q, negate_r,
    output busy, done, div_by_zero, step_cnt
  );
endinterface

// File: rtl/div_control.sv
// Sequencer for a 16-bit restoring signed divider: fetches both operands over Dbus,
// runs 16 shift/subtract steps, then issues sign fix-up; 21 cycles start-to-done with immediate bus_ack.
module div_control (
  input  logic         clk,
  input  logic         rst,
  div_control_if.slave ctl
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LD_DVD = 3'd1;
  localparam logic [2:0] S_LD_DVS = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_ITER   = 3'd4;
  localparam logic [2:0] S_FIX    = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [4:0] LAST_STEP = 5'd15;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [4:0] cnt;
  logic       sign_x;
  logic       sign_r;
  logic       dbz;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (ctl.start) state_nxt = S_LD_DVD;
      S_LD_DVD: if (ctl.bus_ack) state_nxt = S_LD_DVS;
      S_LD_DVS: if (ctl.bus_ack) state_nxt = S_CHECK;
      S_CHECK:  state_nxt = ctl.divisor_zero ? S_DONE : S_ITER;
      S_ITER:   if (cnt == LAST_STEP) state_nxt = S_FIX;
      S_FIX:    state_nxt = S_DONE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // The step counter wraps to 0 after the last step so it reads 0 outside ITER.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= 5'd0;
      sign_x <= 1'b0;
      sign_r <= 1'b0;
      dbz    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (ctl.start) dbz <= 1'b0;
        end
        S_CHECK: begin
          sign_x <= ctl.dividend_sign ^ ctl.divisor_sign;
          sign_r <= ctl.dividend_sign;
          cnt    <= 5'd0;
          dbz    <= ctl.divisor_zero;
        end
        S_ITER: begin
          cnt <= (cnt == LAST_STEP) ? 5'd0 : cnt + 5'd1;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    ctl.Lc       = 2'd0;
    ctl.bus_req  = 1'b0;
    ctl.bus_sel  = 1'b0;
    ctl.shift_en = 1'b0;
    ctl.sub_en   = 1'b0;
    ctl.q_bit    = 1'b0;
    ctl.negate_q = 1'b0;
    ctl.negate_r = 1'b0;
    ctl.done     = 1'b0;
    case (state)
      S_LD_DVD: begin
        ctl.bus_req = 1'b1;
        ctl.Lc      = ctl.bus_ack ? 2'd1 : 2'd0;
      end
      S_LD_DVS: begin
        ctl.bus_req = 1'b1;
        ctl.bus_sel = 1'b1;
        ctl.Lc      = ctl.bus_ack ? 2'd3 : 2'd0;
      end
      S_ITER: begin
        ctl.Lc       = 2'd2;
        ctl.shift_en = 1'b1;
        ctl.sub_en   = ctl.rem_ge;
        ctl.q_bit    = ctl.rem_ge;
      end
      S_FIX: begin
        ctl.negate_q = sign_x;
        ctl.negate_r = sign_r;
      end
      S_DONE: begin
        ctl.done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign ctl.busy        = (state != S_IDLE);
  assign ctl.div_by_zero = dbz;
  assign ctl.step_cnt    = cnt;

endmodule

// File: tb/tb_div_control.sv
// Bench for div_control: a magnitude restoring-division datapath model answers rem_ge,
// stimulus queues expected results, and a negedge monitor scores every cycle and every done.
module tb_div_control;

  typedef struct {
    int          done_cyc;
    logic [15:0] q;
    logic        nq;
    logic        nr;
    logic        dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   ndone = 0;
  exp_t sbq[$];

  div_control_if dif();

  div_control u_dut (
    .clk (clk),
    .rst (rst),
    .ctl (dif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic logic [15:0] mag(input logic [15:0] v);
    return v[15] ? (~v + 16'd1) : v;
  endfunction

  // Operand bus and datapath model: operands as two's complement, datapath works on magnitudes.
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] amag;
  logic [15:0] dmag;
  logic [15:0] rmag;
  logic        sa;
  logic        sb_s;
  logic [16:0] trial;
  logic [16:0] trial_sub;

  assign trial              = {rmag, amag[15]};
  assign trial_sub          = trial - {1'b0, dmag};
  assign dif.rem_ge         = (trial >= {1'b0, dmag});
  assign dif.dividend_sign  = sa;
  assign dif.divisor_sign   = sb_s;
  assign dif.divisor_zero   = (dmag == 16'd0);

  always @(posedge clk) begin
    if (dif.Lc == 2'd1) begin
      amag <= mag(op_a);
      sa   <= op_a[15];
      rmag <= 16'd0;
    end else if (dif.Lc == 2'd3) begin
      dmag <= mag(op_b);
      sb_s <= op_b[15];
    end else if (dif.Lc == 2'd2) begin
      rmag <= dif.sub_en ? trial_sub[15:0] : trial[15:0];
      amag <= {amag[14:0], 1'b0};
    end
  end

  // Bus responder: acks after d1/d2 wait cycles; random ack noise while no request is open.
  int       d1 = 0;
  int       d2 = 0;
  int       wc = 0;
  logic [1:0] last_key = 2'b00;
  logic [1:0] key;

  always @(posedge clk) begin
    #1;
    key = {dif.bus_req, dif.bus_sel};
    if (key != last_key) wc = 0;
    else wc++;
    last_key = key;
    if (dif.bus_req) dif.bus_ack = (wc >= (dif.bus_sel ? d2 : d1));
    else dif.bus_ack = 1'($urandom_range(0, 1));
  end

  // Monitor
  int          it = 0;
  int          n1 = 0;
  int          n3 = 0;
  logic [15:0] qacc = 16'd0;
  logic        nqs = 1'b0;
  logic        nrs = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (!dif.busy) begin
        chk("idle_lc", int'(dif.Lc), 0);
        chk("idle_bus_req", int'(dif.bus_req), 0);
        chk("idle_done", int'(dif.done), 0);
        chk("idle_shift", int'(dif.shift_en), 0);
        chk("idle_step", int'(dif.step_cnt), 0);
        it = 0; n1 = 0; n3 = 0; qacc = 16'd0; nqs = 1'b0; nrs = 1'b0;
      end else begin
        if (dif.bus_req) begin
          chk("lc_load", int'(dif.Lc), dif.bus_ack ? (dif.bus_sel ? 3 : 1) : 0);
          chk("dbz_cleared", int'(dif.div_by_zero), 0);
          if (dif.Lc == 2'd1) n1++;
          if (dif.Lc == 2'd3) n3++;
        end else begin
          chk("lc_no_req", int'(dif.Lc == 2'd1 || dif.Lc == 2'd3), 0);
        end
        if (dif.Lc == 2'd2) begin
          chk("shift_en", int'(dif.shift_en), 1);
          chk("sub_en", int'(dif.sub_en), int'(dif.rem_ge));
          chk("q_bit", int'(dif.q_bit), int'(dif.rem_ge));
          chk("step_cnt", int'(dif.step_cnt), it);
          qacc = {qacc[14:0], dif.q_bit};
          it++;
        end else begin
          chk("shift_off", int'(dif.shift_en | dif.sub_en | dif.q_bit), 0);
          chk("step_off", int'(dif.step_cnt), 0);
        end
        nqs = nqs | dif.negate_q;
        nrs = nrs | dif.negate_r;
        if (dif.done) begin
          ndone++;
          if (sbq.size() == 0) begin
            chk("spurious_done", int'(dif.done), 0);
          end else begin
            e = sbq.pop_front();
            chk("done_cycle", cyc, e.done_cyc);
            chk("iter_count", it, e.dbz ? 0 : 16);
            chk("load_dvd", n1, 1);
            chk("load_dvs", n3, 1);
            if (!e.dbz) chk("quotient", int'(qacc), int'(e.q));
            chk("negate_q", int'(nqs), int'(e.nq));
            chk("negate_r", int'(nrs), int'(e.nr));
            chk("div_by_zero", int'(dif.div_by_zero), int'(e.dbz));
          end
        end
      end
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input int da, input int db, input bit repulse);
    exp_t e;
    int   n0;
    int   k;
    op_a = a;
    op_b = b;
    d1   = da;
    d2   = db;
    e.dbz = (b == 16'd0);
    e.q   = e.dbz ? 16'd0 : mag(a) / mag(b);
    e.nq  = e.dbz ? 1'b0 : (a[15] ^ b[15]);
    e.nr  = e.dbz ? 1'b0 : a[15];
    @(posedge clk); #1;
    e.done_cyc = cyc + (e.dbz ? 4 : 21) + da + db;
    sbq.push_back(e);
    n0 = ndone;
    dif.start = 1'b1;
    @(posedge clk); #1;
    dif.start = 1'b0;
    if (repulse && !e.dbz) begin
      k = 0;
      while (!(dif.shift_en && dif.step_cnt == 5'd5) && k < 100) begin
        @(posedge clk); #1;
        k++;
      end
      dif.start = 1'b1;
      @(posedge clk); #1;
      dif.start = 1'b0;
    end
    k = 0;
    while (ndone == n0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (ndone == n0) begin
      chk("done_timeout", 0, 1);
      sbq.delete();
    end
    chk("idle_after_done", int'(dif.busy), 0);
    if (e.dbz) chk("dbz_held", int'(dif.div_by_zero), 1);
    repeat (2) @(posedge clk);
    #1;
    chk("no_restart", int'(dif.busy), 0);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    dif.start = 1'b0;
    op_a = 16'd0;
    op_b = 16'd1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(dif.busy), 0);
    chk("rst_done", int'(dif.done), 0);
    chk("rst_lc", int'(dif.Lc), 0);
    chk("rst_step", int'(dif.step_cnt), 0);
    chk("rst_dbz", int'(dif.div_by_zero), 0);
    chk("rst_bus_req", int'(dif.bus_req), 0);
    dif.start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    dif.start = 1'b0;
    chk("start_with_rst", int'(dif.busy), 0);
    @(posedge clk); #1;
    chk("start_with_rst_2", int'(dif.busy), 0);

    run_op(16'd100, 16'd7, 0, 0, 1'b0);
    run_op(-16'sd100, 16'd7, 0, 0, 1'b0);
    run_op(16'd100, -16'sd7, 0, 0, 1'b0);
    run_op(16'd1234, 16'd0, 0, 0, 1'b0);
    run_op(16'd100, 16'd7, 3, 2, 1'b0);
    run_op(16'h8000, 16'd3, 1, 0, 1'b0);
    run_op(16'd7, 16'd100, 0, 1, 1'b0);
    run_op(16'd30000, 16'd123, 0, 0, 1'b1);

    // Reset in the middle of the iteration phase, then a clean operation.
    op_a = 16'd5000; op_b = 16'd9; d1 = 0; d2 = 0;
    @(posedge clk); #1;
    dif.start = 1'b1;
    @(posedge clk); #1;
    dif.start = 1'b0;
    k = 0;
    while (!(dif.shift_en && dif.step_cnt == 5'd8) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("reach_step8", int'(dif.step_cnt), 8);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", int'(dif.busy), 0);
    chk("midrst_lc", int'(dif.Lc), 0);
    chk("midrst_step", int'(dif.step_cnt), 0);
    chk("midrst_dbz", int'(dif.div_by_zero), 0);
    run_op(16'd5000, 16'd9, 0, 0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom >> $urandom_range(0, 14));
      run_op(ra, rb, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    chk("queue_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
